// File: rtl/stopwatch_counter.sv
// stopwatch_counter: run/pause/clear stopwatch FSM driving a four-digit BCD M:S1S0.T elapsed-time counter
module stopwatch_counter #(
  parameter int TICK_DIV = 100,
  parameter int PRE_W    = 7
) (
  input  logic       clk,
  input  logic       resetTime,
  input  logic       start_resume,
  input  logic       stop,
  output logic [3:0] sw_min,
  output logic [3:0] sw_sec1,
  output logic [3:0] sw_sec0,
  output logic [3:0] sw_tenth,
  output logic       running,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0] min_q, min_d, sec1_q, sec1_d, sec0_q, sec0_d, tenth_q, tenth_d;
  logic ovf_q, ovf_d, start_prev_q, stop_prev_q, running_q;
  logic start_p, stop_p, tick, clear, c0, c1, c2, c3;
  always_comb begin
    start_p = start_resume & ~start_prev_q;
    stop_p  = stop & ~stop_prev_q;
    state_d = state_q;
    pre_d   = pre_q;
    tick    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: if (start_p && !stop_p) begin
        state_d = RUN;
        pre_d   = '0;
      end
      RUN: if (start_p || stop_p) state_d = PAUSE;
      else begin
        tick  = pre_q == PRE_W'(TICK_DIV - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
      end
      PAUSE: if (stop_p) begin
        state_d = IDLE;
        pre_d   = '0;
        clear   = 1'b1;
      end else if (start_p) state_d = RUN;
      default: state_d = IDLE;
    endcase
    c0      = tick && tenth_q == 4'd9;
    c1      = c0 && sec0_q == 4'd9;
    c2      = c1 && sec1_q == 4'd5;
    c3      = c2 && min_q == 4'd9;
    tenth_d = clear ? 4'd0 : tick ? (c0 ? 4'd0 : tenth_q + 4'd1) : tenth_q;
    sec0_d  = clear ? 4'd0 : c0 ? (c1 ? 4'd0 : sec0_q + 4'd1) : sec0_q;
    sec1_d  = clear ? 4'd0 : c1 ? (c2 ? 4'd0 : sec1_q + 4'd1) : sec1_q;
    min_d   = clear ? 4'd0 : c2 ? (c3 ? 4'd0 : min_q + 4'd1) : min_q;
    ovf_d   = clear ? 1'b0 : ovf_q | c3;
  end
  always_ff @(posedge clk or posedge resetTime) begin
    if (resetTime) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      min_q        <= '0;
      sec1_q       <= '0;
      sec0_q       <= '0;
      tenth_q      <= '0;
      ovf_q        <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      min_q        <= min_d;
      sec1_q       <= sec1_d;
      sec0_q       <= sec0_d;
      tenth_q      <= tenth_d;
      ovf_q        <= ovf_d;
      start_prev_q <= start_resume;
      stop_prev_q  <= stop;
      running_q    <= state_d == RUN;
    end
  end
  assign sw_min   = min_q;
  assign sw_sec1  = sec1_q;
  assign sw_sec0  = sec0_q;
  assign sw_tenth = tenth_q;
  assign running  = running_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed self-checking bench for stopwatch_counter with TICK_DIV=4
module tb_stopwatch_counter;
  logic clk = 1'b0, resetTime = 1'b1, start_resume = 1'b0, stop = 1'b0;
  logic [3:0] sw_min, sw_sec1, sw_sec0, sw_tenth;
  logic running, overflow;
  logic [15:0] dig;
  int checks = 0, errors = 0;
  stopwatch_counter #(.TICK_DIV(4), .PRE_W(3)) dut (
    .clk(clk), .resetTime(resetTime), .start_resume(start_resume), .stop(stop),
    .sw_min(sw_min), .sw_sec1(sw_sec1), .sw_sec0(sw_sec0), .sw_tenth(sw_tenth),
    .running(running), .overflow(overflow)
  );
  assign dig = {sw_min, sw_sec1, sw_sec0, sw_tenth};
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic s, input logic p);
    start_resume = s;
    stop = p;
    step(1);
    start_resume = 1'b0;
    stop = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_dig", 32'(dig), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_ovf", 32'(overflow), 0);
    resetTime = 1'b0;
    step(2);
    press(1, 0);
    chk("start_run", 32'(running), 1);
    step(40);
    chk("dig_40", 32'(dig), 16'h0010);
    step(4);
    chk("dig_44", 32'(dig), 16'h0011);
    step(104);
    chk("dig_037", 32'(dig), 16'h0037);
    #3 resetTime = 1'b1;
    #1;
    chk("async_dig", 32'(dig), 0);
    chk("async_run", 32'(running), 0);
    step(2);
    resetTime = 1'b0;
    step(5);
    chk("post_rst_run", 32'(running), 0);
    chk("post_rst_dig", 32'(dig), 0);
    start_resume = 1'b1;
    step(20);
    start_resume = 1'b0;
    chk("hold_run", 32'(running), 1);
    chk("hold_dig", 32'(dig), 16'h0004);
    step(7);
    chk("pre_pause", 32'(dig), 16'h0006);
    press(0, 1);
    chk("pause_run", 32'(running), 0);
    step(50);
    chk("pause_hold", 32'(dig), 16'h0006);
    press(1, 0);
    chk("resume_run", 32'(running), 1);
    step(1);
    chk("resume_1", 32'(dig), 16'h0006);
    step(1);
    chk("resume_2", 32'(dig), 16'h0007);
    press(0, 1);
    step(1);
    press(0, 1);
    chk("clear_dig", 32'(dig), 0);
    chk("clear_run", 32'(running), 0);
    step(3);
    press(1, 0);
    step(2396);
    chk("dig_0599", 32'(dig), 16'h0599);
    step(4);
    chk("dig_1000", 32'(dig), 16'h1000);
    step(21596);
    chk("dig_9599", 32'(dig), 16'h9599);
    chk("ovf_pre", 32'(overflow), 0);
    step(4);
    chk("wrap_dig", 32'(dig), 0);
    chk("wrap_ovf", 32'(overflow), 1);
    chk("wrap_run", 32'(running), 1);
    press(0, 1);
    chk("ovf_pause", 32'(overflow), 1);
    step(1);
    press(0, 1);
    chk("ovf_clear", 32'(overflow), 0);
    step(2);
    press(1, 0);
    step(5);
    press(1, 1);
    chk("both_run", 32'(running), 0);
    chk("both_dig", 32'(dig), 16'h0001);
    step(1);
    press(1, 1);
    chk("both_clear", 32'(dig), 0);
    chk("both_idle", 32'(running), 0);
    step(1);
    press(1, 1);
    chk("both_idle_stay", 32'(running), 0);
    step(1);
    press(0, 1);
    chk("idle_stop", 32'(running), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
